// File: rtl/wrd_pkg.sv
// Constants and types shared by feature_packer and the wrd accelerator.
// Includes the saturating narrowing helper used by the requantizer.
package wrd_pkg;

   localparam int NUM_COEFFS   = 13;
   localparam int COEFF_IN_BW  = 16;
   localparam int COEFF_OUT_BW = 8;
   localparam int NUM_FRAMES   = 50;
   localparam int VECTOR_BW    = NUM_COEFFS * COEFF_OUT_BW;
   localparam int PACK_CNT_BW  = $clog2(NUM_COEFFS);
   localparam int FRAME_CNT_BW = $clog2(NUM_FRAMES);

   localparam logic signed [COEFF_IN_BW-1:0] Q_MAX = 16'sd127;
   localparam logic signed [COEFF_IN_BW-1:0] Q_MIN = -16'sd128;

   typedef struct packed {
      logic                 last;
      logic [VECTOR_BW-1:0] data;
   } frame_t;

   function automatic logic [COEFF_OUT_BW-1:0] sat_narrow(input logic signed [COEFF_IN_BW-1:0] v);
      logic [COEFF_OUT_BW-1:0] r;
      if (v > Q_MAX) begin
         r = 8'h7F;
      end else if (v < Q_MIN) begin
         r = 8'h80;
      end else begin
         r = v[COEFF_OUT_BW-1:0];
      end
      return r;
   endfunction

endpackage

// File: rtl/feature_packer_frame_fifo.sv
// Two-entry frame FIFO; head_o is always the oldest stored frame.
// A push into a full FIFO or a pop from an empty one is ignored.
module frame_fifo #(
   parameter int WIDTH = 105
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clear_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_o,
   output logic [1:0]       count_o
);

   logic [WIDTH-1:0] head_r;
   logic [WIDTH-1:0] tail_r;
   logic [1:0]       count_r;
   logic             push_s;
   logic             pop_s;

   assign push_s  = push_i && (count_r != 2'd2);
   assign pop_s   = pop_i && (count_r != 2'd0);
   assign head_o  = head_r;
   assign count_o = count_r;

   // Storage and occupancy; a simultaneous push/pop only happens at count 1.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         head_r  <= '0;
         tail_r  <= '0;
         count_r <= 2'd0;
      end else if (clear_i) begin
         count_r <= 2'd0;
      end else begin
         case ({push_s, pop_s})
            2'b10: begin
               if (count_r == 2'd0) begin
                  head_r <= push_data_i;
               end else begin
                  tail_r <= push_data_i;
               end
               count_r <= count_r + 2'd1;
            end
            2'b01: begin
               head_r  <= tail_r;
               count_r <= count_r - 2'd1;
            end
            2'b11: begin
               head_r <= push_data_i;
            end
            default: begin
               count_r <= count_r;
            end
         endcase
      end
   end

endmodule

// File: rtl/feature_packer.sv
// Requantizes signed cepstral coefficients to 8 bits and packs 13 per frame.
// Define FEATURE_PACKER_SAT_EN for saturating narrowing; default truncates (wraps).
module feature_packer
   import wrd_pkg::*;
#(
   parameter int SHIFT = 8
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   clear_i,
   input  logic [COEFF_IN_BW-1:0] coeff_i,
   input  logic                   coeff_valid_i,
   output logic                   coeff_ready_o,
   output logic [VECTOR_BW-1:0]   data_o,
   output logic                   valid_o,
   output logic                   last_o,
   input  logic                   ready_i
);

`ifdef FEATURE_PACKER_SAT_EN
   localparam bit SAT_EN = 1'b1;
`else
   localparam bit SAT_EN = 1'b0;
`endif

   localparam logic [PACK_CNT_BW-1:0]  LAST_IDX   = PACK_CNT_BW'(NUM_COEFFS - 1);
   localparam logic [FRAME_CNT_BW-1:0] LAST_FRAME = FRAME_CNT_BW'(NUM_FRAMES - 1);

   logic [PACK_CNT_BW-1:0]         pack_cnt_r;
   logic [FRAME_CNT_BW-1:0]        frame_cnt_r;
   logic [VECTOR_BW-1:0]           vec_r;
   logic [VECTOR_BW-1:0]           vec_next_s;
   logic signed [COEFF_IN_BW-1:0]  shifted_s;
   logic [COEFF_OUT_BW-1:0]        trunc_s;
   logic [COEFF_OUT_BW-1:0]        sat_s;
   logic [COEFF_OUT_BW-1:0]        q_s;
   logic                           frame_end_s;
   logic                           accept_s;
   logic                           push_s;
   logic                           pop_s;
   frame_t                         push_frame_s;
   frame_t                         head_s;
   logic [1:0]                     fifo_count_s;

   // Requantizer: arithmetic shift, then either clamp or keep the low byte.
   always_comb begin
      shifted_s = $signed(coeff_i) >>> SHIFT;
      trunc_s   = shifted_s[COEFF_OUT_BW-1:0];
      sat_s     = sat_narrow(shifted_s);
      q_s       = SAT_EN ? sat_s : trunc_s;
   end

   // Packing register with the incoming byte merged at slot pack_cnt.
   always_comb begin
      vec_next_s = vec_r;
      for (int k = 0; k < NUM_COEFFS; k++) begin
         if (pack_cnt_r == PACK_CNT_BW'(k)) begin
            vec_next_s[k*COEFF_OUT_BW +: COEFF_OUT_BW] = q_s;
         end else begin
            vec_next_s[k*COEFF_OUT_BW +: COEFF_OUT_BW] = vec_r[k*COEFF_OUT_BW +: COEFF_OUT_BW];
         end
      end
   end

   // Ready depends only on registered state, so no path from ready_i exists.
   assign frame_end_s   = (pack_cnt_r == LAST_IDX);
   assign coeff_ready_o = !(frame_end_s && (fifo_count_s == 2'd2));
   assign accept_s      = coeff_valid_i && coeff_ready_o && !clear_i && !rst_i;
   assign push_s        = accept_s && frame_end_s;
   assign pop_s         = valid_o && ready_i;

   // Completed frame handed to the FIFO in the cycle of the last coefficient.
   always_comb begin
      push_frame_s.last = (frame_cnt_r == LAST_FRAME);
      push_frame_s.data = vec_next_s;
   end

   // Coefficient and frame counters plus the packing register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pack_cnt_r  <= '0;
         frame_cnt_r <= '0;
         vec_r       <= '0;
      end else if (clear_i) begin
         pack_cnt_r  <= '0;
         frame_cnt_r <= '0;
      end else if (accept_s) begin
         vec_r <= vec_next_s;
         if (frame_end_s) begin
            pack_cnt_r <= '0;
            if (frame_cnt_r == LAST_FRAME) begin
               frame_cnt_r <= '0;
            end else begin
               frame_cnt_r <= frame_cnt_r + FRAME_CNT_BW'(1);
            end
         end else begin
            pack_cnt_r <= pack_cnt_r + PACK_CNT_BW'(1);
         end
      end else begin
         pack_cnt_r <= pack_cnt_r;
      end
   end

   frame_fifo #(
      .WIDTH($bits(frame_t))
   ) u_frame_fifo (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .clear_i    (clear_i),
      .push_i     (push_s),
      .push_data_i(push_frame_s),
      .pop_i      (pop_s),
      .head_o     (head_s),
      .count_o    (fifo_count_s)
   );

   assign valid_o = (fifo_count_s != 2'd0);
   assign data_o  = head_s.data;
   assign last_o  = head_s.last;

endmodule

// File: tb/tb_feature_packer.sv
// Scoreboard bench for feature_packer: random and directed stimulus, with a
// frame-level reference model (lists of bytes, frame index, queued vectors).
module tb_feature_packer;
   import wrd_pkg::*;

   logic         clk = 1'b0;
   logic         rst, clr, cv, cr, vo, lo, ri;
   logic [15:0]  ci;
   logic [103:0] dout;

   always #5 clk = ~clk;

   feature_packer dut (
      .clk_i(clk), .rst_i(rst), .clear_i(clr), .coeff_i(ci),
      .coeff_valid_i(cv), .coeff_ready_o(cr), .data_o(dout),
      .valid_o(vo), .last_o(lo), .ready_i(ri)
   );

   typedef struct {
      logic [103:0] d;
      logic         l;
   } exp_t;

   int           total = 0;
   int           bad = 0;
   logic [7:0]   part_q[$];
   exp_t         exp_q[$];
   int           frame_n = 0;
   bit           checks_on = 1'b0;
   bit           stall_prev = 1'b0;
   logic [104:0] held;
   int           last_seen = 0;

   // floor(c / 2^8) in plain integer arithmetic, then narrowed
   function automatic logic [7:0] ref_q(input logic [15:0] c);
      int v, q;
      logic [31:0] qb;
      v = int'($signed(c));
      if (v >= 0) q = v / 256;
      else q = -((-v + 255) / 256);
`ifdef FEATURE_PACKER_SAT_EN
      if (q > 127) q = 127;
      else if (q < -128) q = -128;
`endif
      qb = q;
      return qb[7:0];
   endfunction

   task automatic chk(input string name, input logic [104:0] act, input logic [104:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Monitor/scoreboard: checks against model state, then applies this cycle's handshakes.
   always @(negedge clk) begin
      if (checks_on) begin
         chk("valid_o", 105'(vo), 105'(exp_q.size() != 0));
         chk("coeff_ready_o", 105'(cr), 105'(!(part_q.size() == 12 && exp_q.size() == 2)));
         if (stall_prev) chk("hold", {lo, dout}, held);
         if (rst || clr) begin
            part_q.delete();
            exp_q.delete();
            frame_n = 0;
         end else begin
            if (vo && ri && exp_q.size() != 0) begin
               exp_t e;
               e = exp_q.pop_front();
               chk("data_o", 105'(dout), 105'(e.d));
               chk("last_o", 105'(lo), 105'(e.l));
               if (lo) last_seen++;
            end
            if (cv && cr) begin
               part_q.push_back(ref_q(ci));
               if (part_q.size() == NUM_COEFFS) begin
                  exp_t n;
                  for (int k = 0; k < NUM_COEFFS; k++) n.d[k*8 +: 8] = part_q[k];
                  n.l = (frame_n == NUM_FRAMES - 1);
                  exp_q.push_back(n);
                  frame_n = (frame_n + 1) % NUM_FRAMES;
                  part_q.delete();
               end
            end
         end
         stall_prev = vo && !ri && !rst && !clr;
         held = {lo, dout};
      end
   end

   task automatic cyc(input logic v, input logic [15:0] c, input logic r,
                      input logic cl, input logic rs);
      cv = v; ci = c; ri = r; clr = cl; rst = rs;
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
         n++;
      end
      chk("drain_bound", 105'(exp_q.size()), 105'(0));
   endtask

   logic [103:0] seq_vec;
   logic [15:0]  sat_tbl [0:4];

   initial begin
      rst = 1'b1; clr = 1'b0; cv = 1'b0; ci = 16'h0000; ri = 1'b0;
      sat_tbl[0] = 16'h7FFF; sat_tbl[1] = 16'h8000; sat_tbl[2] = 16'h4000;
      sat_tbl[3] = 16'hFFFF; sat_tbl[4] = 16'h0080;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 105'(vo), 105'(0));
      chk("rst_last", 105'(lo), 105'(0));
      chk("rst_data", 105'(dout), 105'(0));
      chk("rst_ready", 105'(cr), 105'(1));
      rst = 1'b0;
      checks_on = 1'b1;

      // Sequential frame: byte k = k, visible one cycle after the 13th accept
      for (int k = 0; k < NUM_COEFFS; k++) cyc(1'b1, 16'(k * 256), 1'b1, 1'b0, 1'b0);
      for (int k = 0; k < NUM_COEFFS; k++) seq_vec[k*8 +: 8] = 8'(k);
      chk("seq_latency", 105'(vo), 105'(1));
      chk("seq_data", 105'(dout), 105'(seq_vec));
      chk("seq_last", 105'(lo), 105'(0));
      cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);

      // Extreme values
      for (int k = 0; k < NUM_COEFFS; k++)
         cyc(1'b1, (k < 5) ? sat_tbl[k] : 16'($urandom), 1'b1, 1'b0, 1'b0);
      chk("sat_bytes", 105'(dout[39:0]), 105'(40'h00_FF_40_80_7F));
      cyc(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);

      // Long random stream covering a full window and its wrap
      for (int i = 0; i < 1000; i++)
         cyc($urandom_range(0, 9) < 8, 16'($urandom), $urandom_range(0, 3) != 0, 1'b0, 1'b0);
      drain();
      chk("window_last_seen", 105'(last_seen > 0), 105'(1));

      // Back-pressure: 2 frames held, input stalls on the 13th of the third
      cyc(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 39; i++) cyc(1'b1, 16'($urandom), 1'b0, 1'b0, 1'b0);
      chk("bp_stall", 105'(cr), 105'(0));
      cyc(1'b1, 16'($urandom), 1'b1, 1'b0, 1'b0);
      chk("bp_after_pop", 105'(cr), 105'(1));
      cyc(1'b1, 16'($urandom), 1'b0, 1'b0, 1'b0);
      chk("bp_third_in", 105'(vo), 105'(1));
      drain();

      // Clear mid-frame with a coefficient offered in the same cycle
      cyc(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) cyc(1'b1, 16'($urandom), 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 16'h1234, 1'b1, 1'b1, 1'b0);
      chk("clr_valid", 105'(vo), 105'(0));
      for (int i = 0; i < NUM_COEFFS; i++) cyc(1'b1, 16'($urandom), 1'b1, 1'b0, 1'b0);
      chk("clr_frame_out", 105'(vo), 105'(1));
      drain();

      // Reset with the FIFO full
      for (int i = 0; i < 26; i++) cyc(1'b1, 16'($urandom), 1'b0, 1'b0, 1'b0);
      chk("full_before_rst", 105'(vo), 105'(1));
      cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
      chk("mrst_valid", 105'(vo), 105'(0));
      chk("mrst_data", 105'(dout), 105'(0));
      chk("mrst_last", 105'(lo), 105'(0));
      chk("mrst_ready", 105'(cr), 105'(1));

      // Random stream with occasional clear and reset
      for (int i = 0; i < 600; i++)
         cyc($urandom_range(0, 9) < 8, 16'($urandom), $urandom_range(0, 2) != 0,
             $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 1);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
